// File: rtl/fmcrop_pkg.sv
// Shared definitions for the feature-map cropper: register map and config bundle.
// The register map matches the padding block so one driver programs both.
package fmcrop_pkg;

    localparam logic [2:0] ADDR_XON  = 3'd0;
    localparam logic [2:0] ADDR_XOFF = 3'd1;
    localparam logic [2:0] ADDR_XEND = 3'd2;
    localparam logic [2:0] ADDR_YON  = 3'd4;
    localparam logic [2:0] ADDR_YOFF = 3'd5;
    localparam logic [2:0] ADDR_YEND = 3'd6;

    // Fields hold zero-extended, already-truncated register values.
    typedef struct packed {
        logic [31:0] xon;
        logic [31:0] xoff;
        logic [31:0] xend;
        logic [31:0] yon;
        logic [31:0] yoff;
        logic [31:0] yend;
    } cfg_t;

endpackage

// File: rtl/fmcrop_skid.sv
// Two-entry AXI-Stream skid buffer: output register plus one skid register.
// in_ready is registered (!skid_full), so the upstream path is cut combinationally.
module fmcrop_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // valid/ready: a beat transfers on a rising edge where both are high; a
    // raised valid holds, with stable data, until that edge.
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         in_fire;
    logic         out_free;

    assign in_fire  = in_valid && in_ready;
    assign out_free = out_ready || !out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else if (out_free) begin
            // in_ready is low whenever the skid holds a beat, so at most one source loads.
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
            end else begin
                out_valid <= in_fire;
                if (in_fire) out_data <= in_data;
            end
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            if (in_fire) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
            in_ready <= !(skid_valid || in_fire);
        end
    end

endmodule

// File: rtl/fmcrop_axi.sv
// Streaming feature-map cropper: counts beats/columns/rows of the incoming image
// and forwards only the beats inside the configured window.
module fmcrop_axi
    import fmcrop_pkg::*;
#(
    parameter int XCOUNTER_BITS = 8,
    parameter int YCOUNTER_BITS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int SIMD          = 2,
    parameter int ELEM_BITS     = 4,
    localparam int STREAM_BITS  = 8 * (1 + (SIMD * ELEM_BITS - 1) / 8)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   we,
    input  logic [2:0]             wa,
    input  logic [31:0]            wd,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic [STREAM_BITS-1:0] s_axis_tdata,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [STREAM_BITS-1:0] m_axis_tdata
);

    localparam int NF    = NUM_CHANNELS / SIMD;
    localparam int SBITS = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [31:0] XMASK = 32'((64'd1 << XCOUNTER_BITS) - 64'd1);
    localparam logic [31:0] YMASK = 32'((64'd1 << YCOUNTER_BITS) - 64'd1);

    cfg_t                     shadow;
    cfg_t                     active;
    cfg_t                     cfg;
    logic [SBITS-1:0]         s_cnt;
    logic [XCOUNTER_BITS-1:0] x_cnt;
    logic [YCOUNTER_BITS-1:0] y_cnt;
    logic                     in_fire;
    logic                     first_beat;
    logic                     last_s;
    logic                     last_x;
    logic                     last_y;
    logic                     keep;

    // Shadows are deliberately unreset so configuration survives a pipeline reset.
    always_ff @(posedge ap_clk) begin
        if (we) begin
            case (wa)
                ADDR_XON:  shadow.xon  <= wd & XMASK;
                ADDR_XOFF: shadow.xoff <= wd & XMASK;
                ADDR_XEND: shadow.xend <= wd & XMASK;
                ADDR_YON:  shadow.yon  <= wd & YMASK;
                ADDR_YOFF: shadow.yoff <= wd & YMASK;
                ADDR_YEND: shadow.yend <= wd & YMASK;
                default: ;
            endcase
        end
    end

    assign in_fire    = s_axis_tvalid && s_axis_tready;
    assign first_beat = (s_cnt == '0) && (x_cnt == '0) && (y_cnt == '0);
    // The first beat of an image already sees the freshly latched window.
    assign cfg        = first_beat ? shadow : active;

    always_ff @(posedge ap_clk) begin
        if (in_fire && first_beat) active <= shadow;
    end

    assign last_s = (s_cnt == SBITS'(NF - 1));
    assign last_x = (32'(x_cnt) == cfg.xend);
    assign last_y = (32'(y_cnt) == cfg.yend);
    assign keep   = (32'(x_cnt) >= cfg.xon) && (32'(x_cnt) < cfg.xoff) &&
                    (32'(y_cnt) >= cfg.yon) && (32'(y_cnt) < cfg.yoff);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s_cnt <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (in_fire) begin
            if (last_s) begin
                s_cnt <= '0;
                if (last_x) begin
                    x_cnt <= '0;
                    y_cnt <= last_y ? '0 : y_cnt + YCOUNTER_BITS'(1);
                end else begin
                    x_cnt <= x_cnt + XCOUNTER_BITS'(1);
                end
            end else begin
                s_cnt <= s_cnt + SBITS'(1);
            end
        end
    end

    // Dropped beats still handshake upstream; only kept beats enter the skid.
    fmcrop_skid #(
        .W (STREAM_BITS)
    ) u_skid (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (s_axis_tvalid && keep),
        .in_ready  (s_axis_tready),
        .in_data   (s_axis_tdata),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (m_axis_tdata)
    );

endmodule

// File: tb/tb_fmcrop_axi.sv
// Directed bench for fmcrop_axi on a 10x7 image with two beats per pixel.
module tb_fmcrop_axi;
    import fmcrop_pkg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  wa = 3'd0;
    logic [31:0] wd = 32'd0;
    logic        s_axis_tready;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;

    fmcrop_axi dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .we            (we),
        .wa            (wa),
        .wd            (wd),
        .s_axis_tready (s_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata)
    );

    // clock / reset
    always #5 ap_clk = ~ap_clk;
    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard
    logic [7:0] exp_q[$];
    int         out_cnt = 0;
    int         first_valid_cyc = -1;
    int         first_out_cyc = 0;
    int         last_out_cyc = 0;
    logic [7:0] first_data = 8'd0;
    logic [7:0] last_data = 8'd0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    bit         bp_en = 1'b0;
    int         beat_idx = 0;
    int         acc_cnt = 0;
    int         acc_mark = -1;
    int         acc_cyc = 0;

    always @(posedge ap_clk) begin
        #1;
        m_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (prev_stall) begin
                check("hold_valid", m_axis_tvalid, 1'b1);
                check("hold_data", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                check("out_beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("out_data", m_axis_tdata, exp_q.pop_front());
                if (out_cnt == 0) begin
                    first_data    = m_axis_tdata;
                    first_out_cyc = cyc;
                end
                last_data    = m_axis_tdata;
                last_out_cyc = cyc;
                out_cnt++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // driver tasks (called in the posedge+1 phase)
    task automatic clear_stats();
        out_cnt         = 0;
        first_valid_cyc = -1;
    endtask

    task automatic push_expected(input int base, input int xon, input int xoff,
                                 input int yon, input int yoff);
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 10; x++)
                for (int s = 0; s < 2; s++)
                    if (x >= xon && x < xoff && y >= yon && y < yoff)
                        exp_q.push_back(8'(base + (y * 10 + x) * 2 + s));
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        @(posedge ap_clk); #1;
        we = 1'b0;
    endtask

    task automatic set_window(input int xon, input int xoff, input int yon, input int yoff);
        write_reg(ADDR_XON, 32'(xon));
        write_reg(ADDR_XOFF, 32'(xoff));
        write_reg(ADDR_YON, 32'(yon));
        write_reg(ADDR_YOFF, 32'(yoff));
    endtask

    task automatic send_beats(input int n, input bit gaps, input int wr_at,
                              input logic [2:0] wr_a, input logic [31:0] wr_d);
        bit ok;
        int t;
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 4) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge ap_clk); #1;
            end
            if (k == wr_at) begin
                we = 1'b1;
                wa = wr_a;
                wd = wr_d;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(beat_idx);
            ok = 1'b0;
            t  = 0;
            while (!ok && t < 200) begin
                @(negedge ap_clk);
                ok = s_axis_tready;
                @(posedge ap_clk); #1;
                we = 1'b0;
                t++;
            end
            check("in_accept", ok, 1'b1);
            if (!ok) begin
                s_axis_tvalid = 1'b0;
                return;
            end
            if (k == acc_mark) acc_cyc = cyc;
            acc_cnt++;
            beat_idx++;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge ap_clk); #1;
            t++;
        end
        repeat (4) begin
            @(posedge ap_clk); #1;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // configuration is written while reset is still asserted
        @(posedge ap_clk); #1;
        write_reg(ADDR_XON, 32'd2);
        write_reg(ADDR_XOFF, 32'd7);
        write_reg(ADDR_XEND, 32'd9);
        write_reg(ADDR_YON, 32'd1);
        write_reg(ADDR_YOFF, 32'd5);
        write_reg(ADDR_YEND, 32'd6);
        check("rst_m_valid", m_axis_tvalid, 1'b0);
        check("rst_m_data", m_axis_tdata, 8'h00);
        check("rst_s_ready", s_axis_tready, 1'b0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("ready_after_reset", s_axis_tready, 1'b1);

        // 1: default window, free-flowing
        beat_idx = 0;
        clear_stats();
        push_expected(0, 2, 7, 1, 5);
        acc_mark = 24;
        send_beats(140, 1'b0, -1, 3'd0, 32'd0);
        acc_mark = -1;
        drain("s1a");
        check("s1a_count", out_cnt, 40);
        check("s1a_first", first_data, 8'h18);
        check("s1a_last", last_data, 8'h5D);
        check("s1a_latency", first_valid_cyc - acc_cyc, 0);
        clear_stats();
        push_expected(140, 2, 7, 1, 5);
        send_beats(140, 1'b0, -1, 3'd0, 32'd0);
        drain("s1b");
        check("s1b_count", out_cnt, 40);
        check("s1b_first", first_data, 8'hA4);
        check("s1b_last", last_data, 8'hE9);

        // 2: same stimulus, input gaps and output backpressure
        bp_en    = 1'b1;
        beat_idx = 0;
        clear_stats();
        push_expected(0, 2, 7, 1, 5);
        push_expected(140, 2, 7, 1, 5);
        send_beats(140, 1'b1, -1, 3'd0, 32'd0);
        send_beats(140, 1'b1, -1, 3'd0, 32'd0);
        drain("s2");
        bp_en = 1'b0;
        check("s2_count", out_cnt, 80);
        check("s2_last", last_data, 8'hE9);

        // 3: identity window, no bubbles
        set_window(0, 10, 0, 7);
        beat_idx = 0;
        clear_stats();
        push_expected(0, 0, 10, 0, 7);
        send_beats(140, 1'b0, -1, 3'd0, 32'd0);
        drain("s3");
        check("s3_count", out_cnt, 140);
        check("s3_first", first_data, 8'h00);
        check("s3_last", last_data, 8'h8B);
        check("s3_span", last_out_cyc - first_out_cyc + 1, 140);

        // 4: empty window over two images, then identity
        set_window(5, 5, 0, 7);
        clear_stats();
        acc_cnt = 0;
        send_beats(140, 1'b0, -1, 3'd0, 32'd0);
        send_beats(140, 1'b0, -1, 3'd0, 32'd0);
        drain("s4_empty");
        check("s4_empty_count", out_cnt, 0);
        check("s4_accepted", acc_cnt, 280);
        set_window(0, 10, 0, 7);
        beat_idx = 0;
        clear_stats();
        push_expected(0, 0, 10, 0, 7);
        send_beats(140, 1'b0, -1, 3'd0, 32'd0);
        drain("s4_id");
        check("s4_id_count", out_cnt, 140);
        check("s4_id_first", first_data, 8'h00);

        // 5: XOn rewritten mid-image takes effect on the next image
        set_window(2, 7, 1, 5);
        beat_idx = 0;
        clear_stats();
        push_expected(0, 2, 7, 1, 5);
        send_beats(140, 1'b0, 60, ADDR_XON, 32'd0);
        drain("s5a");
        check("s5a_count", out_cnt, 40);
        clear_stats();
        push_expected(140, 0, 7, 1, 5);
        send_beats(140, 1'b0, -1, 3'd0, 32'd0);
        drain("s5b");
        check("s5b_count", out_cnt, 56);
        check("s5b_first", first_data, 8'hA0);

        // 6: reset mid-image
        set_window(2, 7, 1, 5);
        beat_idx = 0;
        clear_stats();
        push_expected(0, 2, 7, 1, 5);
        send_beats(50, 1'b0, -1, 3'd0, 32'd0);
        check("s6_pre_count", out_cnt, 15);
        check("s6_pre_valid", m_axis_tvalid, 1'b1);
        check("s6_pre_data", m_axis_tdata, 8'h31);
        ap_rst_n = 1'b0;
        #1;
        check("s6_rst_valid", m_axis_tvalid, 1'b0);
        check("s6_rst_data", m_axis_tdata, 8'h00);
        check("s6_rst_ready", s_axis_tready, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge ap_clk);
        #1;
        check("s6_rst_ready_held", s_axis_tready, 1'b0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("s6_ready_after", s_axis_tready, 1'b1);
        beat_idx = 0;
        clear_stats();
        push_expected(0, 2, 7, 1, 5);
        send_beats(140, 1'b0, -1, 3'd0, 32'd0);
        drain("s6");
        check("s6_count", out_cnt, 40);
        check("s6_first", first_data, 8'h18);
        check("s6_last", last_data, 8'h5D);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
